// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and window-walk helpers for the LBP engine.
package lbp_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int NB_NUM = 8;

  // Code bit position of each neighbour around the centre pixel.
  localparam int NB_NW = 0;
  localparam int NB_N  = 1;
  localparam int NB_NE = 2;
  localparam int NB_W  = 3;
  localparam int NB_E  = 4;
  localparam int NB_SW = 5;
  localparam int NB_S  = 6;
  localparam int NB_SE = 7;

  typedef enum logic [2:0] {IDLE, FETCH, CAPT, WRITE, DONE} state_t;

  // Row-start fetches walk the 3x3 window column-major, index 0..8.
  function automatic logic [1:0] fetch_row(input logic [3:0] n);
    case (n)
      4'd0, 4'd3, 4'd6: fetch_row = 2'd0;
      4'd1, 4'd4, 4'd7: fetch_row = 2'd1;
      default:          fetch_row = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] fetch_col(input logic [3:0] n);
    case (n)
      4'd0, 4'd1, 4'd2: fetch_col = 2'd0;
      4'd3, 4'd4, 4'd5: fetch_col = 2'd1;
      default:          fetch_col = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/lbp_code.sv
// Combinational LBP code: each bit is set when its neighbour is not darker than the centre.
module lbp_code
  import lbp_pkg::*;
(
  input  logic [DATA_W-1:0]             centre,
  input  logic [NB_NUM-1:0][DATA_W-1:0] nbr,
  output logic [NB_NUM-1:0]             code
);

  always_comb begin
    code = '0;
    for (int i = 0; i < NB_NUM; i++) begin
      code[i] = (nbr[i] >= centre);
    end
  end

endmodule

// File: rtl/lbp_engine.sv
// Frame-level LBP engine: streams a gray image through a 3x3 window and writes
// one code per interior pixel, raster order, then holds finish until reset.
module lbp_engine #(
  parameter int IMG_W  = lbp_pkg::IMG_W,
  parameter int IMG_H  = lbp_pkg::IMG_H,
  parameter int ADDR_W = lbp_pkg::ADDR_W,
  parameter int DATA_W = lbp_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  input  logic [DATA_W-1:0] gray_data,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [DATA_W-1:0] lbp_data,
  output logic              finish
);
  import lbp_pkg::*;

  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  state_t                       state_q, state_d;
  logic [ADDR_W-1:0]            x_q, x_d, y_q, y_d;
  logic [3:0]                   fetch_q, fetch_d;
  logic [2:0][2:0][DATA_W-1:0]  win_q, win_d;
  logic                         gray_req_q, gray_req_d;
  logic [ADDR_W-1:0]            gray_addr_q, gray_addr_d;
  logic                         lbp_valid_q, lbp_valid_d;
  logic [ADDR_W-1:0]            lbp_addr_q, lbp_addr_d;
  logic [DATA_W-1:0]            lbp_data_q, lbp_data_d;
  logic                         finish_q, finish_d;
  logic                         issue_req;
  logic [1:0]                   cap_col, req_row, req_col;
  logic [NB_NUM-1:0][DATA_W-1:0] nbr;
  logic [NB_NUM-1:0]            code;

  always_comb begin
    nbr        = '0;
    nbr[NB_NW] = win_q[0][0];
    nbr[NB_N]  = win_q[0][1];
    nbr[NB_NE] = win_q[0][2];
    nbr[NB_W]  = win_q[1][0];
    nbr[NB_E]  = win_q[1][2];
    nbr[NB_SW] = win_q[2][0];
    nbr[NB_S]  = win_q[2][1];
    nbr[NB_SE] = win_q[2][2];
  end

  lbp_code u_code (
    .centre (win_q[1][1]),
    .nbr    (nbr),
    .code   (code)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    fetch_d     = fetch_q;
    win_d       = win_q;
    issue_req   = 1'b0;
    gray_req_d  = 1'b0;
    gray_addr_d = '0;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = '0;
    lbp_data_d  = '0;
    finish_d    = 1'b0;

    // Data for the request of the ending cycle lands in the slot that request targeted.
    cap_col = (x_q == ONE) ? fetch_col(fetch_q) : 2'd2;
    if (gray_req_q) win_d[fetch_row(fetch_q)][cap_col] = gray_data;

    case (state_q)
      IDLE: begin
        if (gray_ready) begin
          state_d   = FETCH;
          fetch_d   = '0;
          issue_req = 1'b1;
        end
      end
      FETCH: begin
        if (fetch_q == ((x_q == ONE) ? 4'd8 : 4'd2)) begin
          state_d = CAPT;
        end else begin
          fetch_d   = fetch_q + 4'd1;
          issue_req = 1'b1;
        end
      end
      CAPT: begin
        state_d     = WRITE;
        lbp_valid_d = 1'b1;
        lbp_addr_d  = y_q * W_A + x_q;
        lbp_data_d  = DATA_W'(code);
      end
      WRITE: begin
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d  = DONE;
            finish_d = 1'b1;
          end else begin
            x_d       = ONE;
            y_d       = y_q + ONE;
            state_d   = FETCH;
            fetch_d   = '0;
            issue_req = 1'b1;
          end
        end else begin
          // Mid-row: reuse the two right columns, only the new right column is read.
          x_d = x_q + ONE;
          for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
          end
          state_d   = FETCH;
          fetch_d   = '0;
          issue_req = 1'b1;
        end
      end
      DONE:    finish_d = 1'b1;
      default: state_d  = IDLE;
    endcase

    req_row = fetch_row(fetch_d);
    req_col = (x_d == ONE) ? fetch_col(fetch_d) : 2'd2;
    if (issue_req) begin
      gray_req_d  = 1'b1;
      gray_addr_d = (y_d - ONE + ADDR_W'(req_row)) * W_A + (x_d - ONE + ADDR_W'(req_col));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= ONE;
      y_q         <= ONE;
      fetch_q     <= '0;
      win_q       <= '0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fetch_q     <= fetch_d;
      win_q       <= win_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
    end
  end

  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_engine.sv
// Directed frame bench for lbp_engine: full 128-wide rows on a short image so
// every frame keeps the real row timing while staying a few thousand cycles long.
module tb_lbp_engine;

  localparam int W          = 128;
  localparam int H          = 6;
  localparam int AW         = 14;
  localparam int DW         = 8;
  localparam int ROW_CYC    = 11 + (W - 3) * 5;
  localparam int FINISH_CYC = (H - 2) * ROW_CYC + 1;
  localparam int MEM_N      = 1 << AW;

  logic          clk;
  logic          reset;
  logic          gray_ready;
  logic [DW-1:0] gray_data;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;

  logic [DW-1:0] img  [MEM_N];
  logic [DW-1:0] res  [MEM_N];
  logic [DW-1:0] gold [MEM_N];
  logic [DW-1:0] junk;

  int nChecks;
  int nFails;
  int firstWrAddr;
  int lastWrAddr;

  lbp_engine #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_data  (gray_data),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Image memory model: real pixel only while a request is out, junk otherwise.
  always_comb begin
    gray_data = junk;
    if (gray_req) gray_data = img[gray_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int y, input int x);
    return img[AW'(y * W + x)];
  endfunction

  // Straight neighbour-by-neighbour reference code, border left at zero.
  task automatic computeGolden();
    logic [DW-1:0] c;
    logic [7:0]    code;
    for (int a = 0; a < W * H; a++) gold[AW'(a)] = '0;
    for (int y = 1; y < H - 1; y++) begin
      for (int x = 1; x < W - 1; x++) begin
        c       = pix(y, x);
        code[0] = pix(y - 1, x - 1) >= c;
        code[1] = pix(y - 1, x)     >= c;
        code[2] = pix(y - 1, x + 1) >= c;
        code[3] = pix(y,     x - 1) >= c;
        code[4] = pix(y,     x + 1) >= c;
        code[5] = pix(y + 1, x - 1) >= c;
        code[6] = pix(y + 1, x)     >= c;
        code[7] = pix(y + 1, x + 1) >= c;
        gold[AW'(y * W + x)] = code;
      end
    end
  endtask

  task automatic checkQuietOutputs(input string tag, input logic expFinish);
    checkOutput({tag, "_gray_req"},  gray_req,  1'b0);
    checkOutput({tag, "_gray_addr"}, gray_addr, '0);
    checkOutput({tag, "_lbp_valid"}, lbp_valid, 1'b0);
    checkOutput({tag, "_lbp_addr"},  lbp_addr,  '0);
    checkOutput({tag, "_lbp_data"},  lbp_data,  '0);
    checkOutput({tag, "_finish"},    finish,    expFinish);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset      = 1'b1;
    gray_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one frame from IDLE; abortAt > 0 returns early in that cycle, mid-frame.
  task automatic applyStimulus(input int abortAt);
    int  cyc;
    int  expX;
    int  expY;
    int  nWr;
    bit  done;
    for (int a = 0; a < W * H; a++) res[AW'(a)] = '0;
    expX = 1;
    expY = 1;
    nWr  = 0;
    done = 1'b0;
    @(negedge clk);
    gray_ready = 1'b1;
    @(negedge clk);
    gray_ready = 1'b0;
    cyc = 1;
    checkOutput("first_req", gray_req, 1'b1);
    checkOutput("first_addr", gray_addr, 0);
    while (!done && cyc <= FINISH_CYC + 10) begin
      if (lbp_valid) begin
        checkOutput("wr_addr", lbp_addr, expY * W + expX);
        checkOutput("wr_cycle", cyc, (expY - 1) * ROW_CYC + 11 + (expX - 1) * 5);
        res[lbp_addr] = lbp_data;
        if (nWr == 0) firstWrAddr = int'(lbp_addr);
        lastWrAddr = int'(lbp_addr);
        nWr++;
        if (expX == W - 2) begin
          expX = 1;
          expY++;
        end else begin
          expX++;
        end
      end
      if (finish) begin
        checkOutput("finish_cycle", cyc, FINISH_CYC);
        done = 1'b1;
      end else if (cyc == abortAt) begin
        return;
      end else begin
        @(negedge clk);
        junk = DW'($urandom);
        cyc++;
      end
    end
    if (!done) checkOutput("finish_timeout", 0, 1);
    checkOutput("write_count", nWr, (W - 2) * (H - 2));
    checkOutput("first_wr_addr", firstWrAddr, 129);
    checkOutput("last_wr_addr", lastWrAddr, 638);
    repeat (5) @(negedge clk);
    checkQuietOutputs("done", 1'b1);
    computeGolden();
    for (int a = 0; a < W * H; a++) begin
      checkOutput($sformatf("mem[%0d]", a), res[AW'(a)], gold[AW'(a)]);
    end
  endtask

  initial begin
    nChecks    = 0;
    nFails     = 0;
    reset      = 1'b1;
    gray_ready = 1'b0;
    junk       = 8'hA5;
    for (int a = 0; a < MEM_N; a++) img[a] = '0;

    $display("[TB] reset state");
    applyReset();
    checkQuietOutputs("rst", 1'b0);

    $display("[TB] ready held low for 100 cycles");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      junk = DW'($urandom);
      checkOutput("idle_req", gray_req, 1'b0);
    end

    $display("[TB] constant 0x50 image");
    for (int a = 0; a < W * H; a++) img[a] = 8'h50;
    applyStimulus(0);
    checkOutput("const_code", res[AW'(W + 1)], 8'hFF);
    checkOutput("const_border", res[AW'(W)], 8'h00);

    $display("[TB] single bright pixel");
    applyReset();
    for (int a = 0; a < W * H; a++) img[a] = 8'h00;
    img[3 * W + 64] = 8'hFF;
    applyStimulus(0);
    checkOutput("spot_centre", res[AW'(3 * W + 64)], 8'h00);
    checkOutput("spot_left", res[AW'(3 * W + 63)], 8'hFF);
    checkOutput("spot_below", res[AW'(4 * W + 64)], 8'hFF);

    $display("[TB] horizontal ramp gray=x");
    applyReset();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y * W + x] = DW'(x);
    applyStimulus(0);
    checkOutput("ramp_first", res[AW'(W + 1)], 8'hD6);
    checkOutput("ramp_last", res[AW'(4 * W + 126)], 8'hD6);

    $display("[TB] noisy image with mid-frame reset");
    applyReset();
    for (int a = 0; a < W * H; a++) img[a] = DW'($urandom_range(0, 3));
    applyStimulus(1300);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkQuietOutputs("midrst", 1'b0);
    @(negedge clk);
    checkOutput("midrst_idle_req", gray_req, 1'b0);
    applyStimulus(0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
